// File: rtl/mul_pkg.sv
// Shared types for the Booth multiply unit: FSM states, Booth pair decode and default width.
package mul_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ITER   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    BOOTH_NOP = 2'b00,
    BOOTH_ADD = 2'b01,
    BOOTH_SUB = 2'b10
  } booth_op_e;

  // Pair is {current multiplier LSB, previously shifted-out bit E}
  function automatic booth_op_e booth_decode(input logic a0, input logic e);
    case ({a0, e})
      2'b01:   return BOOTH_ADD;
      2'b10:   return BOOTH_SUB;
      default: return BOOTH_NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_mul_ctrl_if.sv
// Request/response bundle between the control sequencer and the multiply unit.
interface booth_mul_ctrl_if #(
  parameter int WIDTH = 32
) ();
  // start is a one-cycle request honoured only while busy is low (no queuing);
  // done/hi_en/lo_en pulse together for one cycle when hi_out/lo_out take the product.
  logic             start;
  logic             cancel;
  logic [WIDTH-1:0] mplr;
  logic [WIDTH-1:0] mcand;
  logic             busy;
  logic             done;
  logic             hi_en;
  logic             lo_en;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output start, cancel, mplr, mcand,
    input  busy, done, hi_en, lo_en, hi_out, lo_out
  );

  modport slave (
    input  start, cancel, mplr, mcand,
    output busy, done, hi_en, lo_en, hi_out, lo_out
  );
endinterface

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of Y into the upper part, then arithmetic shift right.
module booth_step
  import mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [2*WIDTH:0] acc_i,
  input  logic             e_i,
  input  logic [WIDTH-1:0] y_i,
  output logic [2*WIDTH:0] acc_o,
  output logic             e_o
);

  logic [WIDTH:0] upper;
  logic [WIDTH:0] y_ext;
  logic [WIDTH:0] upper_nxt;

  assign upper = acc_i[2*WIDTH:WIDTH];
  assign y_ext = {y_i[WIDTH-1], y_i};

  // The extra guard bit keeps -2^(W-1) * -2^(W-1) from overflowing the upper part
  always_comb begin
    upper_nxt = upper;
    case (booth_decode(acc_i[0], e_i))
      BOOTH_ADD: upper_nxt = upper + y_ext;
      BOOTH_SUB: upper_nxt = upper + ~y_ext + {{WIDTH{1'b0}}, 1'b1};
      default:   upper_nxt = upper;
    endcase
  end

  assign acc_o = {upper_nxt[WIDTH], upper_nxt, acc_i[WIDTH-1:1]};
  assign e_o   = acc_i[0];

endmodule

// File: rtl/booth_mul_ctrl.sv
// Multi-cycle signed multiplier: one Booth step per clock, product committed to HI/LO.
module booth_mul_ctrl
  import mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic              clock,
  input  logic              clear_n,
  booth_mul_ctrl_if.slave   bus,
  output state_e            dbg_state
);

  state_e               state_q, state_d;
  logic [2*WIDTH:0]     acc_q, acc_d;
  logic                 e_q, e_d;
  logic [WIDTH-1:0]     y_q, y_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  logic [2*WIDTH:0]     acc_step;
  logic                 e_step;
  logic                 accept;
  logic                 last_step;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc_i (acc_q),
    .e_i   (e_q),
    .y_i   (y_q),
    .acc_o (acc_step),
    .e_o   (e_step)
  );

  // Cancel outranks a same-cycle start, so a flushed request never launches
  assign accept    = (state_q == IDLE) && bus.start && !bus.cancel;
  assign last_step = (count_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      e_q     <= 1'b0;
      y_q     <= '0;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      e_q     <= e_d;
      y_q     <= y_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ITER;
      ITER: begin
        if (bus.cancel)     state_d = IDLE;
        else if (last_step) state_d = COMMIT;
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_d   = acc_q;
    e_d     = e_q;
    y_d     = y_q;
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (accept) begin
      y_d     = bus.mcand;
      acc_d   = {{(WIDTH+1){1'b0}}, bus.mplr};
      e_d     = 1'b0;
      count_d = '0;
    end else if (state_q == ITER && !bus.cancel) begin
      acc_d   = acc_step;
      e_d     = e_step;
      count_d = count_q + CNT_W'(1);
    end else if (state_q == COMMIT) begin
      {hi_d, lo_d} = acc_q[2*WIDTH-1:0];
    end
  end

  always_comb begin
    bus.busy  = (state_q != IDLE);
    bus.done  = (state_q == COMMIT);
    bus.hi_en = (state_q == COMMIT);
    bus.lo_en = (state_q == COMMIT);
  end

  assign bus.hi_out = hi_q;
  assign bus.lo_out = lo_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/booth_mul_ctrl.md
Name: booth_mul_ctrl

Overview:
- Multi-cycle signed multiply unit for the CPU datapath, driven by the control sequencer for the MUL instruction.
- Holds a radix-2 Booth engine and retires one multiplier bit per clock.
- Uses a start/busy/done handshake and writes the 2*WIDTH-bit product into the HI/LO registers through write enables.
- Replaces the single-cycle combinational multiplier on the critical path.

Parameters:
- WIDTH, 32, operand width in bits. The product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH), width of the iteration counter.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- clear_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request; sampled only in IDLE.
- cancel  in  1  synchronous abort, e.g. on an exception or pipeline flush.
- mplr  in  WIDTH  multiplier (signed); captured when start is accepted.
- mcand  in  WIDTH  multiplicand (signed); captured when start is accepted.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse when the product is committed.
- hi_en  out  1  HI register write enable; same cycle as done.
- lo_en  out  1  LO register write enable; same cycle as done.
- hi_out  out  WIDTH  product[2W-1:W]; registered, held until the next commit.
- lo_out  out  WIDTH  product[W-1:0]; registered, held until the next commit.

Behaviour:
- Reset (clear_n=0, asynchronous):
  - state=IDLE; busy, done, hi_en, lo_en=0.
  - hi_out, lo_out=0; accumulator, E, count=0.
  - Reset asserted mid-operation discards the operation; no done is produced.
- States: IDLE, ITER, COMMIT.
- IDLE:
  - start=1 -> latch mcand into Y_q.
  - acc = {(W+1)'b0, mplr}; acc is 2W+1 bits, upper part W+1 bits (sign guard bit).
  - E=0, count=0; go to ITER.
- ITER, one Booth step per cycle:
  - {acc[0],E}=10 -> upper -= sext(Y_q), true two's complement (~Y+1).
  - {acc[0],E}=01 -> upper += sext(Y_q).
  - 00 or 11 -> no add.
  - Then E <= acc[0]; acc <= arithmetic shift right by 1 (MSB replicated).
  - count++; after the step with count==WIDTH-1, go to COMMIT.
- COMMIT, exactly one cycle:
  - done=hi_en=lo_en=1.
  - {hi_out,lo_out} <= acc[2W-1:0].
  - Go to IDLE.
- Latency:
  - start accepted in cycle 0 -> ITER in cycles 1..WIDTH -> COMMIT in cycle WIDTH+1 (33 for the default).
  - hi_out/lo_out show the new product from cycle WIDTH+2.
  - Back-to-back: start is accepted again in the first IDLE cycle after COMMIT.
- start while busy: ignored; no queuing.
- cancel:
  - In ITER -> IDLE next cycle; no done, no enables; hi_out/lo_out keep their old value.
  - In COMMIT -> ignored; the commit completes.
  - In IDLE -> ignored, and takes priority over a same-cycle start (the request is dropped).
- Arithmetic: the guard bit makes mcand = -2^(W-1) exact for all mplr, with no overflow. The result equals the full signed product mod 2^(2W).
- Outputs: done, hi_en, lo_en are decoded from state (registered state, no combinational path from inputs).

Decomposition:
- Package mul_pkg holds:
  - the state enum (IDLE/ITER/COMMIT);
  - the Booth pair encodings (BOOTH_NOP, BOOTH_ADD, BOOTH_SUB);
  - the default WIDTH constant.
- One natural sub-module, booth_step:
  - combinational; inputs acc, E, Y.
  - outputs next acc and next E (add/sub plus arithmetic shift).
  - the controller instantiates it once and owns the FSM, counter and output registers.

Test Plan:
- Basic: mplr=15, mcand=3 -> done in cycle 33 after start; HI=0x00000000, LO=0x0000002D; busy high cycles 1..33.
- Sign: mplr=-7, mcand=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then mplr=3, mcand=-7 gives the same result.
- Extremes:
  - 0x80000000*0x80000000 -> HI=0x40000000, LO=0x00000000.
  - mplr=0xFFFFFFFF, mcand=0x80000000 -> HI=0x00000000, LO=0x80000000.
- Handshake:
  - A second start pulsed in cycle 10 with other operands is ignored; the first product is committed.
  - A start on the cycle right after done is accepted.
- Cancel at cycle 12 -> busy low in cycle 13; no done or enables; hi_out/lo_out keep the prior product (e.g. 0x2D).
- clear_n pulsed low mid-ITER -> all outputs 0 immediately (asynchronous). A new start then returns the correct product 6*7=42.
